fq_pkt_fifo: RTL

Per-channel store-and-forward packet buffer that sits directly upstream of the fair-queue scheduler, one instance per scheduler input. It accepts a framed 64-bit word stream, holds each packet until its last word arrives, and patches the packet word count into header bits [7:0]. It then presents complete packets to the scheduler through a show-ahead FIFO read interface. The scheduler therefore never selects a partial packet and never underruns mid-burst.

---
 rtl/fq_pkt_fifo_pkg.sv | 24 ++
 rtl/fq_pkt_fifo_ram.sv | 23 ++
 rtl/fq_pkt_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fq_pkt_fifo_pkg.sv
// Shared types and constants for the fair-queue packet buffer.
// The optional FQ_PKT_STATS_EN build adds packet/drop counters in the top.
package fq_pkg;

  localparam int DATA_W      = 64;
  localparam int LEN_W       = 8;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = LEN_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    PATCH,
    DROP
  } wr_state_e;

  function automatic logic [DATA_W-1:0] patch_hdr(
    input logic [DATA_W-1:LEN_W] upper,
    input logic [LEN_W-1:0]      len
  );
    return {upper, len};
  endfunction

endpackage

// File: rtl/fq_pkt_fifo_ram.sv
// Packet storage: one synchronous write port, one asynchronous read port.
module fq_pkt_ram
  import fq_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fq_pkt_fifo.sv
// Store-and-forward packet buffer: commits whole packets with the word count
// patched into header[7:0]; FQ_PKT_STATS_EN enables pkt_count/drop_count.
module fq_pkt_fifo
  import fq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int MAX_WORDS  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              fifo_rdreq,
  output logic              fifo_empty,
  output logic [DATA_W-1:0] fifo_data,
  output logic              drop_pulse,
  output logic              rd_err,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count
);

  localparam int PW   = DEPTH_LOG2 + 1;
  localparam int LEN1 = LEN_W + 1;
  localparam logic [PW-1:0]   DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0]   PONE        = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [LEN1-1:0] MAX_LEN     = LEN1'(MAX_WORDS);

  wr_state_e              state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          start_ptr_q, start_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          pkts_q, pkts_d;
  logic [DATA_W-1:LEN_W]  hdr_q, hdr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       rd_left_q, rd_left_d;
  logic                   drop_pulse_q, drop_pulse_d;
  logic                   rd_err_q, rd_err_d;

  logic                   ram_we;
  logic [DEPTH_LOG2-1:0]  ram_waddr;
  logic [DATA_W-1:0]      ram_wdata;
  logic                   accept, commit, rd_hdr, full;
  logic                   sop_start;
  logic [PW-1:0]          sop_base;
  logic [LEN1-1:0]        len_next;

  fq_pkt_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (fifo_data)
  );

  assign full       = ((wr_ptr_q - rd_ptr_q) == DEPTH_WORDS);
  assign in_ready   = rst && !full && (state_q != PATCH);
  assign accept     = in_valid && in_ready;
  assign fifo_empty = (pkts_q == '0);
  assign drop_pulse = drop_pulse_q;
  assign rd_err     = rd_err_q;
  assign len_next   = {1'b0, len_q} + LEN1'(1);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    start_ptr_d  = start_ptr_q;
    hdr_d        = hdr_q;
    len_d        = len_q;
    drop_pulse_d = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q[DEPTH_LOG2-1:0];
    ram_wdata    = in_data;
    commit       = 1'b0;
    sop_start    = 1'b0;
    sop_base     = wr_ptr_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sop) sop_start = 1'b1;
          else        drop_pulse_d = 1'b1;
        end
      end
      BODY: begin
        if (accept) begin
          if (in_sop) begin
            // Abort rewinds to the old header slot, which the new packet reuses.
            drop_pulse_d = 1'b1;
            sop_start    = 1'b1;
            sop_base     = start_ptr_q;
          end else if (len_next > MAX_LEN) begin
            wr_ptr_d     = start_ptr_q;
            drop_pulse_d = 1'b1;
            state_d      = in_eop ? IDLE : DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PONE;
            len_d    = len_next[LEN_W-1:0];
            if (in_eop) state_d = PATCH;
          end
        end
      end
      PATCH: begin
        ram_we    = 1'b1;
        ram_waddr = start_ptr_q[DEPTH_LOG2-1:0];
        ram_wdata = patch_hdr(hdr_q, len_q);
        commit    = 1'b1;
        state_d   = IDLE;
      end
      DROP: begin
        if (accept) begin
          if (in_sop)      sop_start = 1'b1;
          else if (in_eop) state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sop_start) begin
      ram_we    = 1'b1;
      ram_waddr = sop_base[DEPTH_LOG2-1:0];
      wr_ptr_d  = sop_base + PONE;
      if (in_eop) begin
        ram_wdata = patch_hdr(in_data[DATA_W-1:LEN_W], LEN_W'(1));
        commit    = 1'b1;
        state_d   = IDLE;
      end else begin
        start_ptr_d = sop_base;
        hdr_d       = in_data[DATA_W-1:LEN_W];
        len_d       = LEN_W'(1);
        state_d     = BODY;
      end
    end
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    rd_left_d = rd_left_q;
    rd_err_d  = rd_err_q;
    rd_hdr    = 1'b0;
    if (fifo_rdreq) begin
      if (rd_left_q != '0) begin
        rd_left_d = rd_left_q - LEN_W'(1);
        rd_ptr_d  = rd_ptr_q + PONE;
      end else if (pkts_q != '0) begin
        rd_left_d = fifo_data[HDR_LEN_MSB:HDR_LEN_LSB] - LEN_W'(1);
        rd_ptr_d  = rd_ptr_q + PONE;
        rd_hdr    = 1'b1;
      end else begin
        rd_err_d  = 1'b1;
      end
    end
    pkts_d = pkts_q;
    if (commit && !rd_hdr)      pkts_d = pkts_q + PONE;
    else if (!commit && rd_hdr) pkts_d = pkts_q - PONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      pkts_q       <= '0;
      hdr_q        <= '0;
      len_q        <= '0;
      rd_left_q    <= '0;
      drop_pulse_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkts_q       <= pkts_d;
      hdr_q        <= hdr_d;
      len_q        <= len_d;
      rd_left_q    <= rd_left_d;
      drop_pulse_q <= drop_pulse_d;
      rd_err_q     <= rd_err_d;
    end
  end

`ifdef FQ_PKT_STATS_EN
  logic [15:0] pkt_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (commit && pkt_cnt_q != '1)        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
      if (drop_pulse_d && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule
